// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle on sign-stripped magnitudes,
// sign fix-up in a final cycle, divide-by-zero and signed overflow on a fast path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state, state_nx;
  logic [2*XLEN-1:0] prod;      // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   mcand;     // multiplicand or divisor magnitude
  logic [CW-1:0]     count;
  logic [2:0]        f3_q;
  logic              neg_q, sign_a_q;
  logic [XLEN-1:0]   result_q;

  logic              a_signed, b_signed, sign_a_in, sign_b_in;
  logic              is_special, accept;
  logic [XLEN-1:0]   special_res, mag_a, mag_b;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_signed;
  logic [XLEN-1:0]   quo, rem, fix_res;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_signed    = 1'b0;
    b_signed    = 1'b0;
    is_special  = 1'b0;
    special_res = '0;
    if (bus.funct3[2]) begin
      a_signed = ~bus.funct3[0];
      b_signed = ~bus.funct3[0];
    end else begin
      a_signed = (bus.funct3[1:0] != 2'b11);
      b_signed = ~bus.funct3[1];
    end
    if (bus.funct3[2]) begin
      if (bus.op_b == '0) begin
        is_special  = 1'b1;
        special_res = bus.funct3[1] ? bus.op_a : '1;
      end else if (a_signed && bus.op_a == MIN_NEG && bus.op_b == '1) begin
        is_special  = 1'b1;
        special_res = bus.funct3[1] ? '0 : MIN_NEG;
      end
    end
  end

  assign sign_a_in = a_signed & bus.op_a[XLEN-1];
  assign sign_b_in = b_signed & bus.op_b[XLEN-1];
  assign mag_a     = sign_a_in ? -bus.op_a : bus.op_a;
  assign mag_b     = sign_b_in ? -bus.op_b : bus.op_b;
  assign accept    = bus.start && (state == S_IDLE || state == S_DONE);

  // Shift-add step and restoring-divide step share the product register.
  assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, prod[XLEN-1:1]};
  assign rem_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
  assign diff     = rem_sh - {1'b0, mcand};
  assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],   prod[XLEN-2:0], 1'b1};

  always_comb begin
    prod_signed = neg_q ? -prod : prod;
    quo         = prod[XLEN-1:0];
    rem         = prod[2*XLEN-1:XLEN];
    fix_res     = '0;
    if (f3_q[2])
      fix_res = f3_q[1] ? (sign_a_q ? -rem : rem) : (neg_q ? -quo : quo);
    else
      fix_res = (f3_q[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) state_nx = is_special ? S_DONE : (bus.funct3[2] ? S_DIV : S_MUL);
        else           state_nx = S_IDLE;
      end
      S_MUL, S_DIV: if (count == CW'(XLEN-1)) state_nx = S_FIX;
      S_FIX:        state_nx = S_DONE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    bus.done = (state == S_DONE);
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves result at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod     <= '0;
      mcand    <= '0;
      count    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      f3_q     <= bus.funct3;
      neg_q    <= sign_a_in ^ sign_b_in;
      sign_a_q <= sign_a_in;
      count    <= '0;
      prod     <= {{XLEN{1'b0}}, bus.funct3[2] ? mag_a : mag_b};
      mcand    <= bus.funct3[2] ? mag_b : mag_a;
      if (is_special) result_q <= special_res;
    end else begin
      unique case (state)
        S_MUL: begin
          prod  <= mul_next;
          count <= count + 1'b1;
        end
        S_DIV: begin
          prod  <= div_next;
          count <= count + 1'b1;
        end
        S_FIX:   result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, busy/done shape,
// fast paths, ignored mid-op start, back-to-back accept and async reset abort.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) mif ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(mif));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit disturb);
    int lat, nbusy;
    @(negedge clk);
    mif.start = 1'b1; mif.funct3 = f; mif.op_a = a; mif.op_b = b;
    @(negedge clk);
    mif.start = 1'b0;
    lat = 1; nbusy = 0;
    while (!mif.done && lat < 100) begin
      if (mif.busy) nbusy++;
      if (disturb && lat == 5) begin
        mif.start = 1'b1; mif.funct3 = 3'b100; mif.op_a = 32'h1234_5678; mif.op_b = 32'd1;
      end
      if (disturb && lat == 6) mif.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " result"}, mif.result, exp);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    check({tag, " busy at done"}, 32'(mif.busy), 32'd0);
    @(negedge clk);
    check({tag, " done pulse width"}, 32'(mif.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    reset = 1'b1;
    mif.start = 1'b0; mif.funct3 = '0; mif.op_a = '0; mif.op_b = '0;
    #1;
    check("reset busy", 32'(mif.busy), 32'd0);
    check("reset done", 32'(mif.done), 32'd0);
    check("reset result", mif.result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
    run_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0);
    run_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0);
    run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);
    run_op("DIVU 100/7",      3'b101, 32'd100,       32'd7,         32'd14,        34, 1'b0);
    run_op("REMU 100/7",      3'b111, 32'd100,       32'd7,         32'd2,         34, 1'b0);
    run_op("DIVU 5/0",        3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("REMU 5/0",        3'b111, 32'd5,         32'd0,         32'd5,         1,  1'b0);
    run_op("DIV overflow",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    run_op("REM overflow",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);
    run_op("MUL 7*3 disturb", 3'b000, 32'd7,         32'd3,         32'd21,        34, 1'b1);

    // start held high: ignored while busy, accepted again in the DONE cycle
    @(negedge clk);
    mif.start = 1'b1; mif.funct3 = 3'b011; mif.op_a = 32'hFFFF_FFFF; mif.op_b = 32'hFFFF_FFFF;
    @(negedge clk);
    lat = 1;
    while (!mif.done && lat < 100) begin @(negedge clk); lat++; end
    check("b2b first result", mif.result, 32'hFFFF_FFFE);
    check("b2b first latency", 32'(lat), 32'd34);
    mif.funct3 = 3'b111; mif.op_a = 32'd100; mif.op_b = 32'd7;
    @(negedge clk);
    mif.start = 1'b0;
    check("b2b second busy", 32'(mif.busy), 32'd1);
    lat = 1;
    while (!mif.done && lat < 100) begin @(negedge clk); lat++; end
    check("b2b second result", mif.result, 32'd2);
    check("b2b second latency", 32'(lat), 32'd34);

    // async reset at iteration 10 of a multiply
    @(negedge clk);
    mif.start = 1'b1; mif.funct3 = 3'b000; mif.op_a = 32'h0000_FFFF; mif.op_b = 32'h0000_FFFF;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-abort busy", 32'(mif.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort busy", 32'(mif.busy), 32'd0);
    check("abort done", 32'(mif.done), 32'd0);
    check("abort result", mif.result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (mif.done || mif.busy) seen++;
    end
    check("no activity after abort", 32'(seen), 32'd0);
    check("result after abort", mif.result, 32'd0);
    run_op("DIVU 9/3 after reset", 3'b101, 32'd9, 32'd3, 32'd3, 34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
